// File: rtl/clkfrec_multi.sv
// N-channel programmable clock divider: per-channel square wave, rise-aligned tick,
// runtime divisor reload that takes effect only on a period boundary.
module clkfrec_multi #(
    parameter int unsigned F_IN      = 100_000_000,
    parameter int unsigned N_CH      = 4,
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned DEF_F_OUT = 25_000_000,
    localparam int unsigned CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  pend
);
    localparam int unsigned DEF_DIV = F_IN / DEF_F_OUT;

    if (DEF_DIV < 2 || 64'(DEF_DIV) >= (64'd1 << DIV_W)) begin : g_bad_def_div
        $error("clkfrec_multi: DEF_DIV=%0d outside [2, 2**DIV_W-1]", DEF_DIV);
    end
    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("clkfrec_multi: N_CH=%0d outside [1, 16]", N_CH);
    end

    logic [DIV_W-1:0] cnt_q  [N_CH];
    logic [DIV_W-1:0] cnt_d  [N_CH];
    logic [DIV_W-1:0] div_q  [N_CH];
    logic [DIV_W-1:0] div_d  [N_CH];
    logic [DIV_W-1:0] pdiv_q [N_CH];
    logic [DIV_W-1:0] pdiv_d [N_CH];
    logic [N_CH-1:0]  run_q, run_d;
    logic [N_CH-1:0]  pend_q, pend_d;
    logic [N_CH-1:0]  clk_q, clk_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic             err_q, err_d;
    logic             ch_ok, wr_ok;
    logic [N_CH-1:0]  wr_hit, at_end;

    // Next-state: write qualification, run/stop, boundary apply of a pending divisor
    always_comb begin
        ch_ok  = (32'(cfg_ch) < N_CH);
        wr_ok  = cfg_we && ch_ok && (cfg_div >= DIV_W'(2));
        err_d  = cfg_we && !wr_ok;
        wr_hit = '0;
        at_end = '0;
        run_d  = run_q;
        pend_d = pend_q;
        tick_d = '0;
        clk_d  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            pdiv_d[i] = pdiv_q[i];
            at_end[i] = run_q[i] && (cnt_q[i] == div_q[i] - DIV_W'(1));
            wr_hit[i] = wr_ok && (cfg_ch == CH_W'(i));

            if (!ch_en[i]) begin
                // Stopping commits any pending divisor so the restart uses it
                cnt_d[i] = '0;
                run_d[i] = 1'b0;
                if (pend_q[i]) begin
                    div_d[i]  = pdiv_q[i];
                    pend_d[i] = 1'b0;
                end
                if (wr_hit[i]) begin
                    if (run_q[i]) begin
                        pdiv_d[i] = cfg_div;
                        pend_d[i] = 1'b1;
                    end else begin
                        div_d[i]  = cfg_div;
                        pend_d[i] = 1'b0;
                    end
                end
            end else if (!run_q[i]) begin
                cnt_d[i] = '0;
                run_d[i] = 1'b1;
                if (wr_hit[i]) begin
                    pdiv_d[i] = cfg_div;
                    pend_d[i] = 1'b1;
                end
            end else begin
                if (at_end[i]) begin
                    cnt_d[i]  = '0;
                    tick_d[i] = 1'b1;
                    if (pend_q[i]) begin
                        div_d[i]  = pdiv_q[i];
                        pend_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + DIV_W'(1);
                end
                if (wr_hit[i]) begin
                    pdiv_d[i] = cfg_div;
                    pend_d[i] = 1'b1;
                end
            end

            clk_d[i] = run_d[i] && (cnt_d[i] < (div_d[i] >> 1));
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= DIV_W'(DEF_DIV);
                pdiv_q[i] <= DIV_W'(DEF_DIV);
            end
            run_q  <= '0;
            pend_q <= '0;
            clk_q  <= '0;
            tick_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pdiv_q[i] <= pdiv_d[i];
            end
            run_q  <= run_d;
            pend_q <= pend_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            err_q  <= err_d;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pend    = pend_q;
    assign cfg_err = err_q;

endmodule

// File: tb/tb_clkfrec_multi.sv
// Bench for clkfrec_multi: cycle-time reference model compared every cycle,
// plus directed sequences with hand-computed waveform literals.
module tb_clkfrec_multi;
    localparam int unsigned N     = 3;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEF_D = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  ch_en;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [DW-1:0] cfg_div;
    logic          cfg_err;
    logic [N-1:0]  clk_out, tick, pend;

    int n_tests = 0;
    int n_fail  = 0;

    clkfrec_multi #(
        .F_IN(100_000_000), .N_CH(N), .DIV_W(DW), .DEF_F_OUT(25_000_000)
    ) dut (
        .clk_in(clk), .reset(reset), .ch_en(ch_en), .cfg_we(cfg_we),
        .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick), .pend(pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: each channel's phase is elapsed edges since its period started
    int         cyc = 0;
    bit         m_valid = 1'b0;
    bit         m_run  [N];
    bit         m_pend [N];
    int         m_div  [N];
    int         m_pdiv [N];
    int         m_start[N];
    logic [N-1:0] m_clk = '0, m_tick = '0, m_pv = '0;
    logic       m_err = 1'b0;

    always @(posedge clk) begin
        bit acc;
        bit wr;
        cyc++;
        if (reset) begin
            m_valid = 1'b1;
            m_err = 1'b0; m_clk = '0; m_tick = '0; m_pv = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i] = 1'b0; m_pend[i] = 1'b0; m_div[i] = DEF_D;
                m_pdiv[i] = DEF_D; m_start[i] = cyc;
            end
        end else begin
            acc    = cfg_we && (int'(cfg_ch) < N) && (int'(cfg_div) >= 2);
            m_err  = cfg_we && !acc;
            m_tick = '0;
            for (int i = 0; i < N; i++) begin
                wr = acc && (int'(cfg_ch) == i);
                if (!ch_en[i]) begin
                    if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
                    if (wr) begin
                        if (m_run[i]) begin m_pdiv[i] = int'(cfg_div); m_pend[i] = 1'b1; end
                        else begin m_div[i] = int'(cfg_div); m_pend[i] = 1'b0; end
                    end
                    m_run[i] = 1'b0;
                end else if (!m_run[i]) begin
                    m_run[i] = 1'b1;
                    m_start[i] = cyc;
                    if (wr) begin m_pdiv[i] = int'(cfg_div); m_pend[i] = 1'b1; end
                end else begin
                    if (cyc - m_start[i] == m_div[i]) begin
                        m_start[i] = cyc;
                        m_tick[i] = 1'b1;
                        if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
                    end
                    if (wr) begin m_pdiv[i] = int'(cfg_div); m_pend[i] = 1'b1; end
                end
                m_clk[i] = m_run[i] && ((cyc - m_start[i]) < m_div[i] / 2);
                m_pv[i]  = m_pend[i];
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model clk_out", 32'(clk_out), 32'(m_clk));
            check("model tick",    32'(tick),    32'(m_tick));
            check("model pend",    32'(pend),    32'(m_pv));
            check("model cfg_err", 32'(cfg_err), 32'(m_err));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Collects n samples of one channel, first sample ends up in the MSB
    task automatic grab(input int ch, input int n, output logic [31:0] c,
                        output logic [31:0] t, output logic [31:0] p);
        c = '0; t = '0; p = '0;
        for (int k = 0; k < n; k++) begin
            step(1);
            c = {c[30:0], clk_out[ch]};
            t = {t[30:0], tick[ch]};
            p = {p[30:0], pend[ch]};
        end
    endtask

    task automatic wr(input logic [1:0] ch, input int d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = DW'(d);
    endtask

    logic [31:0] c, t, p;
    logic [N-1:0] exp_clk [5];

    initial begin
        reset = 1'b1; ch_en = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
        step(2);
        check("reset clk_out", 32'(clk_out), 32'h0);
        check("reset tick",    32'(tick),    32'h0);
        check("reset pend",    32'(pend),    32'h0);
        check("reset cfg_err", 32'(cfg_err), 32'h0);

        // Default divisor 4 on ch0
        reset = 1'b0; ch_en = 3'b001;
        grab(0, 8, c, t, p);
        check("ch0 D4 wave", c, 32'b11001100);
        check("ch0 D4 tick", t, 32'b00001000);
        check("ch1/2 idle",  32'(clk_out[2:1]), 32'h0);

        // Immediate divisor write on a stopped channel
        wr(2'd1, 5); step(1); cfg_we = 1'b0;
        check("ch1 no pend idle write", 32'(pend[1]), 32'h0);
        ch_en = 3'b011;
        grab(1, 10, c, t, p);
        check("ch1 D5 wave", c, 32'b1100011000);
        check("ch1 D5 tick", t, 32'b0000010000);
        check("ch1 D5 pend", p, 32'h0);

        // Reload mid-period: old period finishes, then D=10
        ch_en = 3'b010; step(1);
        ch_en = 3'b011; step(2);
        wr(2'd0, 10); step(1); cfg_we = 1'b0;
        check("ch0 pend set", 32'(pend[0]), 32'h1);
        check("ch0 old period low", 32'(clk_out[0]), 32'h0);
        grab(0, 12, c, t, p);
        check("ch0 reload wave", c, 32'b011111000001);
        check("ch0 reload tick", t, 32'b010000000001);
        check("ch0 reload pend", p, 32'b100000000000);

        // Rejected writes
        wr(2'd0, 1); step(1);
        check("err div<2", 32'(cfg_err), 32'h1);
        check("err div<2 no pend", 32'(pend[0]), 32'h0);
        wr(2'd3, 7); step(1); cfg_we = 1'b0;
        check("err ch>=N", 32'(cfg_err), 32'h1);
        step(1);
        check("err one cycle", 32'(cfg_err), 32'h0);

        // Write landing on the boundary that applies an earlier pending value
        ch_en = 3'b111; step(1);
        wr(2'd2, 6); step(1); cfg_we = 1'b0;
        check("ch2 pend 6", 32'(pend[2]), 32'h1);
        step(2);
        wr(2'd2, 8); step(1); cfg_we = 1'b0;
        check("ch2 bnd clk",  32'(clk_out[2]), 32'h1);
        check("ch2 bnd tick", 32'(tick[2]),    32'h1);
        check("ch2 bnd pend", 32'(pend[2]),    32'h1);
        grab(2, 14, c, t, p);
        check("ch2 6then8 wave", c, 32'b11000111100001);
        check("ch2 6then8 tick", t, 32'b00000100000001);
        check("ch2 6then8 pend", p, 32'b11111000000000);

        // Mid-period reset, then in-phase restart at the default divisor
        reset = 1'b1; step(1);
        check("mid reset clk_out", 32'(clk_out), 32'h0);
        check("mid reset tick",    32'(tick),    32'h0);
        check("mid reset pend",    32'(pend),    32'h0);
        reset = 1'b0;
        exp_clk[0] = 3'b111; exp_clk[1] = 3'b111; exp_clk[2] = 3'b000;
        exp_clk[3] = 3'b000; exp_clk[4] = 3'b111;
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("restart phase", 32'(clk_out), 32'(exp_clk[k]));
        end
        check("restart tick", 32'(tick), 32'h7);

        // Disable while pending commits the new divisor
        wr(2'd1, 6); step(1); cfg_we = 1'b0;
        check("ch1 pend before stop", 32'(pend[1]), 32'h1);
        ch_en = 3'b101; step(1);
        check("ch1 stop pend", 32'(pend[1]), 32'h0);
        check("ch1 stop clk",  32'(clk_out[1]), 32'h0);
        ch_en = 3'b111;
        grab(1, 7, c, t, p);
        check("ch1 D6 restart wave", c, 32'b1110001);
        check("ch1 D6 restart tick", t, 32'b0000001);

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
